// File: rtl/apb_req_bridge_pkg.sv
// Shared types for the APB requester: FSM states and the
// command/response bundles that move through the bridge.
package apb_req_bridge_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          write;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  function automatic logic aligned(input logic [AW-1:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; full/empty come from a registered
// occupancy count so req_ready never depends on the pop side.
module cmd_fifo
  import apb_req_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P1 = 1;
  localparam logic [PW:0]   C1 = 1;
  localparam logic [PW:0]   CF = (PW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CF);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + P1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + P1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + C1;
        2'b01:   count <= count - C1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_req_bridge.sv
// APB3 requester: queued valid/ready commands in, one ordered
// response per command out, with timeout and alignment errors.
module apb_req_bridge
  import apb_req_bridge_pkg::*;
#(
  parameter int ADDR_W    = AW,
  parameter int DATA_W    = DW,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T1   = 1;

  state_e        state;
  cmd_t          in_cmd;
  cmd_t          head;
  rsp_t          rsp;
  logic          full;
  logic          empty;
  logic          pop;
  logic          rsp_free;
  logic [TW-1:0] tcnt;

  assign in_cmd    = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !full;
  assign rsp_free  = !rsp_valid || rsp_ready;
  assign pop       = (state == IDLE) && !empty && rsp_free;

  assign rsp_write = rsp.write;
  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;

  cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      rsp       <= '0;
      rsp_valid <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      if (rsp_valid && rsp_ready)
        rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (aligned(head.addr)) begin
              psel   <= 1'b1;
              pwrite <= head.write;
              paddr  <= head.addr;
              pwdata <= head.wdata;
              state  <= SETUP;
            end else begin
              // misaligned: answer locally, bus untouched
              rsp_valid <= 1'b1;
              rsp       <= '{write: head.write, rdata: '0, err: 1'b1};
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp.write <= pwrite;
            rsp.err   <= pslverr;
            rsp.rdata <= (!pwrite && !pslverr) ? prdata : '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (tcnt == TMAX) begin
            rsp_valid <= 1'b1;
            rsp       <= '{write: pwrite, rdata: '0, err: 1'b1};
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + T1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench: ALU-style APB slave model plus an in-order
// response scoreboard fed at command acceptance.
module tb_apb_req_bridge;
  import apb_req_bridge_pkg::*;

  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        rsp_valid;
  logic        rsp_ready = 1;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;
  rsp_t exp_q[$];

  logic        stall = 0;
  logic        psel_seen = 0;
  logic [31:0] reg_a = 0, reg_b = 0, reg_c = 0, res;

  always #5 clk = ~clk;

  apb_req_bridge dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  // operand/ALU slave: 0 A, 4 B, 8 ctl, C result (read-only)
  always_comb begin
    res = 32'h0;
    case (reg_c)
      32'd1: res = reg_a & reg_b;
      32'd2: res = reg_a | reg_b;
      32'd3: res = reg_a ^ reg_b;
      default: res = 32'h0;
    endcase
    case (paddr[3:0])
      4'h0: prdata = reg_a;
      4'h4: prdata = reg_b;
      4'h8: prdata = reg_c;
      4'hC: prdata = res;
      default: prdata = 32'h0;
    endcase
  end
  assign pready  = !stall;
  assign pslverr = psel && penable && pwrite && paddr[3:0] == 4'hC;

  always @(posedge clk) begin
    if (psel) psel_seen = 1;
    if (psel && penable && pready && pwrite && !pslverr)
      case (paddr[3:0])
        4'h0: reg_a = pwdata;
        4'h4: reg_b = pwdata;
        4'h8: reg_c = pwdata;
        default: ;
      endcase
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("stale_rsp", rsp_valid, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_write", rsp_write, e.write);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] er,
                      input logic ee, input bit push = 1);
    bit ok = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("send_ready", req_ready, 1);
    end else begin
      @(posedge clk); #1;
      if (push) exp_q.push_back('{write: w, rdata: er, err: ee});
    end
    req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(posedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int accepted;
    int cyc;
    logic [31:0] baddr [8];
    logic [31:0] bval;
    baddr = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8, 32'h0, 32'h4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    reset = 0;

    // ALU sequence
    send(1, 32'h0, 32'hAAAAAAAA, 0, 0);
    send(1, 32'h4, 32'h0F0F0F0F, 0, 0);
    send(1, 32'h8, 32'h1, 0, 0);
    send(0, 32'hC, 0, 32'h0A0A0A0A, 0);
    send(1, 32'h8, 32'h2, 0, 0);
    send(0, 32'hC, 0, 32'hAFAFAFAF, 0);
    send(1, 32'h8, 32'h3, 0, 0);
    send(0, 32'hC, 0, 32'hA5A5A5A5, 0);
    drain();

    // latency from accept edge
    send(0, 32'h0, 0, 32'hAAAAAAAA, 0);
    chk("lat_psel_n", psel, 0);
    @(posedge clk); #1;
    chk("lat_psel_n1", psel, 1);
    chk("lat_pen_n1", penable, 0);
    @(posedge clk); #1;
    chk("lat_pen_n2", penable, 1);
    chk("lat_rspv_n2", rsp_valid, 0);
    @(posedge clk); #1;
    chk("lat_rspv_n3", rsp_valid, 1);
    send(1, 32'h0, 32'hAAAAAAAA, 0, 0);
    drain();

    // back-pressure: 1 in response reg + 4 queued
    rsp_ready = 0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_write = 0; req_addr = baddr[i];
      @(negedge clk);
      if (req_ready) begin
        case (baddr[i])
          32'h0: bval = 32'hAAAAAAAA;
          32'h4: bval = 32'h0F0F0F0F;
          default: bval = 32'h3;
        endcase
        exp_q.push_back('{write: 1'b0, rdata: bval, err: 1'b0});
        accepted++;
      end
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("bp_accepted", accepted, 5);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    rsp_ready = 1;
    drain();

    // timeout
    stall = 1;
    send(0, 32'h4, 0, 0, 1);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (penable) cyc++;
    end
    chk("to_cycles", cyc, 16);
    chk("to_psel", psel, 0);
    stall = 0;
    drain();

    // PSLVERR
    send(1, 32'hC, 32'h1234, 0, 1);
    drain();

    // misaligned then aligned
    psel_seen = 0;
    send(0, 32'h2, 0, 0, 1);
    drain();
    chk("mis_no_psel", psel_seen, 0);
    send(0, 32'h4, 0, 32'h0F0F0F0F, 0);
    drain();

    // reset mid-ACCESS
    stall = 1;
    send(0, 32'h0, 0, 0, 0, 0);
    send(1, 32'h4, 32'h5555, 0, 0, 0);
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    chk("rst_pre_pen", penable, 1);
    #2 reset = 1;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_paddr", paddr, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    reset = 0;
    stall = 0;
    psel_seen = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_psel", psel_seen, 0);
    chk("post_rst_rspv", rsp_valid, 0);
    send(0, 32'h4, 0, 32'h0F0F0F0F, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
